// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// The helpers work on widths up to MAX_W so one definition serves every W.
package mul_pkg;

  localparam int MAX_W  = 64;
  localparam int MAX_PW = 2 * MAX_W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Magnitude of a w-bit operand. In signed mode a negative value is negated
  // within w bits, so the most negative value maps onto 2^(w-1).
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value,
                                             input logic is_signed,
                                             input int w);
    logic [MAX_W-1:0] mask;
    logic             sign;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    sign = |(value & (MAX_W'(1) << (w - 1)));
    if (is_signed && sign) begin
      abs_w = (~value + MAX_W'(1)) & mask;
    end else begin
      abs_w = value & mask;
    end
  endfunction

  // A 2w-bit product fits in w bits when, unsigned, its upper half is zero,
  // or, signed, its top w+1 bits are all copies of the sign bit.
  function automatic logic ovf_chk(input logic [MAX_PW-1:0] p,
                                   input logic is_signed,
                                   input int w);
    logic [MAX_PW-1:0] upper;
    logic [MAX_PW-1:0] ones;
    if (is_signed) begin
      upper   = p >> (w - 1);
      ones    = {MAX_PW{1'b1}} >> (MAX_PW - (w + 1));
      ovf_chk = (upper != '0) && (upper != ones);
    end else begin
      ovf_chk = (p >> w) != '0;
    end
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier with valid/ready on both sides.
// One W+1-bit adder; W iteration cycles plus one finish cycle per product.
// Supports W up to mul_pkg::MAX_W.
module seq_multiplier #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic [W-1:0]   y,
  output logic           ovf
);

  import mul_pkg::*;

  localparam int CW = $clog2(W + 1);

  state_t         state;
  state_t         next_state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc_hi;
  logic [W-1:0]   mplier;
  logic [W-1:0]   mcand;
  logic           neg;
  logic           sgn_mode;
  logic [W:0]     sum;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_final;
  logic           ovf_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; BUSY ends after the finish cycle
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = BUSY;
      end
      BUSY: begin
        if (cnt == CW'(W)) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Adder, full unsigned product and sign-corrected result with its overflow flag
  always_comb begin
    sum        = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
    prod       = {acc_hi, mplier};
    prod_final = neg ? -prod : prod;
    ovf_next   = ovf_chk(MAX_PW'(prod_final), sgn_mode, W);
  end

  // Operand latch at accept, one shift-add step per BUSY cycle, result capture on finish
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc_hi   <= '0;
      mplier   <= '0;
      mcand    <= '0;
      neg      <= 1'b0;
      sgn_mode <= 1'b0;
      p        <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= W'(abs_w(MAX_W'(a), is_signed, W));
            mplier   <= W'(abs_w(MAX_W'(b), is_signed, W));
            neg      <= is_signed & (a[W-1] ^ b[W-1]);
            sgn_mode <= is_signed;
            acc_hi   <= '0;
            cnt      <= '0;
          end
        end
        BUSY: begin
          if (cnt == CW'(W)) begin
            p   <= prod_final;
            ovf <= ovf_next;
            cnt <= '0;
          end else begin
            acc_hi <= sum[W:1];
            mplier <= {sum[0], mplier[W-1:1]};
            cnt    <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign y = p[W-1:0];

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at W=16.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic [15:0] y;
  logic        ovf;

  int assertCount = 0;
  int failCount   = 0;

  seq_multiplier #(.W(16)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p(p),
    .y(y),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Wait for in_ready, present one transaction and pass the accepting edge
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic sg);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
    a         = av;
    b         = bv;
    is_signed = sg;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  // Count cycles from the accepting edge until out_valid, bounded
  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  // Output handshake, then confirm the block is idle again
  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_out_valid_after_hs"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_in_ready_after_hs"}, 64'(in_ready), 64'd1);
  endtask

  task automatic runTxn(input string tag, input logic [15:0] av,
                        input logic [15:0] bv, input logic sg,
                        input logic [31:0] expP, input logic expOvf);
    int lat;
    applyStimulus(av, bv, sg);
    waitResult(lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd17);
    checkOutput({tag, "_p"}, 64'(p), 64'(expP));
    checkOutput({tag, "_y"}, 64'(y), 64'(expP[15:0]));
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(expOvf));
    consume(tag);
  endtask

  initial begin
    int lat;
    logic [31:0] heldP;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_p", 64'(p), 64'd0);
    checkOutput("reset_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    step();
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Basic products and overflow boundaries
    out_ready = 1'b1;
    runTxn("u3x5", 16'h0003, 16'h0005, 1'b0, 32'h0000000F, 1'b0);
    out_ready = 1'b0;
    runTxn("uFFFFxFFFF", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1);
    runTxn("sm3x5", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b0);
    runTxn("s8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1);
    runTxn("sm1xm1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0);
    runTxn("u0x1234", 16'h0000, 16'h1234, 1'b0, 32'h00000000, 1'b0);
    runTxn("u8000x2", 16'h8000, 16'h0002, 1'b0, 32'h00010000, 1'b1);
    runTxn("s4000x2", 16'h4000, 16'h0002, 1'b1, 32'h00008000, 1'b1);
    runTxn("sC000x2", 16'hC000, 16'h0002, 1'b1, 32'hFFFF8000, 1'b0);

    // Backpressure: result must hold while out_ready stays low
    applyStimulus(16'h0006, 16'h0007, 1'b0);
    waitResult(lat);
    checkOutput("bp_latency", 64'(lat), 64'd17);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("bp_out_valid_held", 64'(out_valid), 64'd1);
      checkOutput("bp_p_held", 64'(p), 64'h2A);
      checkOutput("bp_ovf_held", 64'(ovf), 64'd0);
      checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    consume("bp");

    // Operand changes mid-BUSY are ignored; a held in_valid waits for IDLE
    applyStimulus(16'h0010, 16'h0003, 1'b0);
    for (int i = 0; i < 4; i++) step();
    a         = 16'hFFFF;
    b         = 16'hFFFF;
    is_signed = 1'b1;
    in_valid  = 1'b1;
    checkOutput("mid_busy_in_ready", 64'(in_ready), 64'd0);
    lat = 4;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    checkOutput("mid_busy_latency", 64'(lat), 64'd17);
    checkOutput("mid_busy_p", 64'(p), 64'h30);
    step();
    checkOutput("held_valid_not_taken_in_done", 64'(out_valid), 64'd1);
    consume("mid_busy");
    step();
    in_valid = 1'b0;
    checkOutput("second_accepted", 64'(in_ready), 64'd0);
    waitResult(lat);
    checkOutput("second_latency", 64'(lat), 64'd17);
    checkOutput("second_p", 64'(p), 64'h1);
    checkOutput("second_ovf", 64'(ovf), 64'd0);
    consume("second");

    // Reset mid-transaction aborts it; result never appears
    heldP = p;
    checkOutput("p_nonzero_before_abort", 64'(heldP != 32'd0), 64'd1);
    applyStimulus(16'h0007, 16'h0009, 1'b0);
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_p", 64'(p), 64'd0);
    checkOutput("abort_ovf", 64'(ovf), 64'd0);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) lat++;
    end
    checkOutput("abort_no_result", 64'(lat), 64'd0);
    runTxn("u2x2", 16'h0002, 16'h0002, 1'b0, 32'h00000004, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
